mux_scan_ctrl: RTL and testbench

Sequencer that drives the 4-bit select of the team's 16-channel counter/mux datapath. It steps through a programmable subset of channels and holds each channel for a programmable dwell time. It supports single-sweep and continuous modes and uses a start/stop/done handshake. It sits between the control logic and the mux select input, and replaces the free-running select counter.

---
 rtl/mux_scan_pkg.sv | 12 +
 rtl/mux_scan_ctrl_ch_find_next.sv | 32 +++
 rtl/mux_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared defaults and state encoding for the channel-scan sequencer.
// Used by the top and the channel-search helper.
package mux_scan_pkg;
  localparam int SEL_W_DEF   = 4;
  localparam int NCH_DEF     = 2 ** SEL_W_DEF;
  localparam int DWELL_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } scan_state_t;
endpackage

// File: rtl/mux_scan_ctrl_ch_find_next.sv
// Combinational channel search: lowest set bit above cur, plus lowest set bit overall.
// Zero latency, no flow control.
module ch_find_next
  import mux_scan_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  localparam int NCH  = 2 ** SEL_W
) (
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] next_idx,
  output logic             found_above,
  output logic [SEL_W-1:0] first_idx
);

  // Scanning downward leaves the lowest qualifying index in each result.
  always_comb begin
    next_idx    = '0;
    found_above = 1'b0;
    first_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first_idx = SEL_W'(i);
        if (i > int'(cur)) begin
          next_idx    = SEL_W'(i);
          found_above = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Mux select sequencer: walks enabled channels, holding each dwell+1 cycles; first sel_valid 1 cycle after start.
// No backpressure: start is dropped while busy, stop is deferred to the end of the current channel.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SEL_W   = SEL_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF,
  localparam int NCH    = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [NCH-1:0]     ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               continuous,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               ch_strobe,
  output logic               busy,
  output logic               done
);

  scan_state_t        state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               sel_valid_q, sel_valid_d;
  logic               ch_strobe_q, ch_strobe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [NCH-1:0]     mask_l_q, mask_l_d;
  logic [DWELL_W-1:0] dwell_l_q, dwell_l_d;
  logic               cont_l_q, cont_l_d;
  logic               stop_pend_q, stop_pend_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;

  logic [NCH-1:0]     find_mask;
  logic [SEL_W-1:0]   next_idx, first_idx;
  logic               found_above;
  logic               stop_now;

  // In IDLE the search looks at the incoming mask (first channel); otherwise the latched one.
  assign find_mask = (state_q == IDLE) ? ch_mask : mask_l_q;

  ch_find_next #(.SEL_W(SEL_W)) u_find (
    .mask        (find_mask),
    .cur         (sel_q),
    .next_idx    (next_idx),
    .found_above (found_above),
    .first_idx   (first_idx)
  );

  assign stop_now = stop_pend_q | stop;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    ch_strobe_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mask_l_d    = mask_l_q;
    dwell_l_d   = dwell_l_q;
    cont_l_d    = cont_l_q;
    stop_pend_d = stop_pend_q;
    dwell_cnt_d = dwell_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (ch_mask != '0) begin
            mask_l_d    = ch_mask;
            dwell_l_d   = dwell;
            cont_l_d    = continuous;
            stop_pend_d = stop;
            sel_d       = first_idx;
            dwell_cnt_d = '0;
            state_d     = DWELL;
            sel_valid_d = 1'b1;
            busy_d      = 1'b1;
            ch_strobe_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      DWELL: begin
        stop_pend_d = stop_now;
        if (dwell_cnt_q == dwell_l_q) begin
          dwell_cnt_d = '0;
          if (stop_now || (!found_above && !cont_l_q)) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            sel_valid_d = 1'b0;
            busy_d      = 1'b0;
            stop_pend_d = 1'b0;
          end else begin
            sel_d       = found_above ? next_idx : first_idx;
            ch_strobe_d = 1'b1;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      ch_strobe_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mask_l_q    <= '0;
      dwell_l_q   <= '0;
      cont_l_q    <= 1'b0;
      stop_pend_q <= 1'b0;
      dwell_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      ch_strobe_q <= ch_strobe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mask_l_q    <= mask_l_d;
      dwell_l_q   <= dwell_l_d;
      cont_l_q    <= cont_l_d;
      stop_pend_q <= stop_pend_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign ch_strobe = ch_strobe_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl; observed byte is {sel, sel_valid, ch_strobe, busy, done}.
module tb_mux_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, continuous;
  logic [15:0] ch_mask;
  logic [7:0]  dwell;
  logic [3:0]  sel;
  logic        sel_valid, ch_strobe, busy, done;
  logic [7:0]  obs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_scan_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .ch_mask    (ch_mask),
    .dwell      (dwell),
    .continuous (continuous),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .ch_strobe  (ch_strobe),
    .busy       (busy),
    .done       (done)
  );

  assign obs = {sel, sel_valid, ch_strobe, busy, done};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mask 0x0005, dwell 2, single sweep: ch0 x3, ch2 x3, done, sel holds 2.
  task automatic run_t1(input string pfx);
    logic [7:0] exp [8];
    exp = '{8'h0E, 8'h0A, 8'h0A, 8'h2E, 8'h2A, 8'h2A, 8'h21, 8'h20};
    ch_mask = 16'h0005; dwell = 8'd2; continuous = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_c%0d", pfx, k + 1), obs, exp[k]);
      tick();
    end
  endtask

  initial begin
    logic [7:0] e3 [6];
    logic [7:0] e4 [10];
    int n_str, last_k, first_k, done_k;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    ch_mask = '0; dwell = '0;
    #2;
    chk("reset_obs", obs, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_obs", obs, 8'h00);

    // Stop in IDLE is ignored.
    stop = 1'b1; tick(); stop = 1'b0;
    chk("idle_stop", obs, 8'h00);

    run_t1("t1");

    // Empty mask: one done pulse, sel keeps 2.
    ch_mask = 16'h0000; start = 1'b1; tick(); start = 1'b0;
    chk("t2_c1", obs, 8'h21);
    tick(); chk("t2_c2", obs, 8'h20);
    tick(); chk("t2_c3", obs, 8'h20);

    // Continuous 0/15 ping-pong, stop while on 15.
    e3 = '{8'h0E, 8'hFE, 8'h0E, 8'hFE, 8'hF1, 8'hF0};
    ch_mask = 16'h8001; dwell = 8'd0; continuous = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t3_c%0d", k + 1), obs, e3[k]);
      if (k == 3) stop = 1'b1;
      tick();
      stop = 1'b0;
    end

    // Mid-sweep start and input changes are ignored.
    e4 = '{8'h0E, 8'h0A, 8'h0A, 8'h0A, 8'h1E, 8'h1A, 8'h1A, 8'h1A, 8'h11, 8'h10};
    ch_mask = 16'h0003; dwell = 8'd3; continuous = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t4_c%0d", k + 1), obs, e4[k]);
      if (k == 1) begin
        start = 1'b1; ch_mask = 16'hFFFF; dwell = 8'd0; continuous = 1'b1;
      end
      tick();
      start = 1'b0;
    end

    // Full mask, max dwell.
    ch_mask = 16'hFFFF; dwell = 8'd255; continuous = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    n_str = 0; last_k = 0; first_k = -1; done_k = -1;
    for (int k = 1; k <= 5000 && done_k < 0; k++) begin
      if (ch_strobe) begin
        chk("t5_sel", sel, n_str);
        if (n_str > 0) chk("t5_gap", k - last_k, 256);
        last_k = k;
        n_str++;
      end
      if (sel_valid && first_k < 0) first_k = k;
      if (done) done_k = k;
      else tick();
    end
    chk("t5_done_seen", done_k > 0, 1);
    chk("t5_strobes", n_str, 16);
    chk("t5_done_lat", done_k - first_k, 4096);
    chk("t5_final", obs, 8'hF1);
    tick();

    // Async reset mid-dwell on channel 5.
    ch_mask = 16'h0020; dwell = 8'd10; continuous = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk("t6_pre", obs, 8'h5A);
    #3 rst_n = 1'b0;
    #1 chk("t6_async", obs, 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t6_hold%0d", k), obs, 8'h00);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("t6_release", obs, 8'h00);
    run_t1("t6_t1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
